// File: rtl/ir_array_intf.sv
// ir_array_intf: N-channel IR reflectance-sensor front end.
// Generates a windowed, duty-programmable PWM emitter enable, samples the
// active-low sensor inputs at the end of each emitter window through a
// two-stage synchroniser, then debounces each channel and optionally blanks
// it after a rise. Produces clean levels, one-cycle rise pulses and a
// sample-valid strobe.
module ir_array_intf #(
  parameter int NUM_CH   = 3,
  parameter int TMR_W    = 17,
  parameter int BLANK_W  = 23,
  parameter int FILT     = 2,
  parameter int FAST_SIM = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] IR_n,
  input  logic [2:0]        duty,
  input  logic [NUM_CH-1:0] blank_mask,
  output logic              IR_en,
  output logic [NUM_CH-1:0] IR,
  output logic [NUM_CH-1:0] IR_rise,
  output logic              smpl_vld
);

  // Effective period-timer and blanking-timer widths.
  localparam int P    = (FAST_SIM != 0) ? TMR_W - 3 : TMR_W;
  localparam int B    = (FAST_SIM != 0) ? BLANK_W - 6 : BLANK_W;
  localparam int DC_W = $clog2(FILT + 1);

  logic [P-1:0]        tmr;
  logic                ir_on;
  logic                strobe;
  logic [2:0]          duty_lat;
  logic [2:0]          pc;
  logic [2:0]          eff;

  logic [NUM_CH-1:0]   s1;
  logic [NUM_CH-1:0]   s2;
  logic                stb_d1;
  logic                stb_d2;

  logic [DC_W-1:0]     dc     [NUM_CH];
  logic [DC_W-1:0]     dc_nxt [NUM_CH];
  logic [BLANK_W-1:0]  bt     [NUM_CH];
  logic [BLANK_W-1:0]  bt_nxt [NUM_CH];
  logic [NUM_CH-1:0]   blankover;
  logic [NUM_CH-1:0]   ir_nxt;

  // Emitter window is the first sixteenth of the period; the strobe marks
  // its last cycle, when the reflected signal has had longest to settle.
  assign ir_on  = (tmr[P-1:P-4] == 4'd0);
  assign strobe = ir_on && (&tmr[P-5:0]);
  assign eff    = ir_on ? duty_lat : 3'd0;

  // Free-running period timer, PWM phase counter and per-window duty latch.
  // NOTE: every clocked block uses non-blocking assignments so all flops
  // sample pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr      <= '0;
      pc       <= '0;
      duty_lat <= '0;
    end else begin
      tmr <= tmr + P'(1);
      pc  <= pc + 3'd1;
      if (tmr == '0) duty_lat <= duty;
    end
  end

  // Emitter enable: set at the start of each 8-clock PWM frame, cleared once
  // the phase reaches the effective duty. Clear wins over set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IR_en <= 1'b0;
    end else if (pc >= eff) begin
      IR_en <= 1'b0;
    end else if (pc == 3'd0) begin
      IR_en <= 1'b1;
    end
  end

  // Capture on the strobe, resynchronise, and carry the strobe alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      s2       <= '0;
      stb_d1   <= 1'b0;
      stb_d2   <= 1'b0;
      smpl_vld <= 1'b0;
    end else begin
      if (strobe) s1 <= ~IR_n;
      s2       <= s1;
      stb_d1   <= strobe;
      stb_d2   <= stb_d1;
      smpl_vld <= stb_d2;
    end
  end

  // A channel is out of blanking once the low B bits of its timer saturate.
  always_comb begin
    blankover = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      blankover[i] = &bt[i][B-1:0];
    end
  end

  // Per-channel debounce and blanking next-state.
  // NOTE: every target gets a default at the top so no path leaves a value
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ir_nxt = IR;
    dc_nxt = dc;
    bt_nxt = bt;
    for (int i = 0; i < NUM_CH; i++) begin
      if (stb_d2 && blankover[i]) begin
        if (s2[i] == IR[i]) begin
          dc_nxt[i] = '0;
        end else if (int'(dc[i]) + 1 == FILT) begin
          ir_nxt[i] = s2[i];
          dc_nxt[i] = '0;
        end else begin
          dc_nxt[i] = dc[i] + DC_W'(1);
        end
      end
      // A masked rise (re)starts the blank, even if one is already running.
      if (IR_rise[i] && blank_mask[i]) begin
        bt_nxt[i] = '0;
      end else if (!blankover[i]) begin
        bt_nxt[i] = bt[i] + BLANK_W'(1);
      end
    end
  end

  // Register clean levels, rise pulses, debounce counters and blank timers.
  // NOTE: the per-channel arrays are small register files and must be reset:
  // the blank timers start all-ones so no channel begins in blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IR      <= '0;
      IR_rise <= '0;
      dc      <= '{default: '0};
      bt      <= '{default: '1};
    end else begin
      IR      <= ir_nxt;
      IR_rise <= ir_nxt & ~IR;
      dc      <= dc_nxt;
      bt      <= bt_nxt;
    end
  end

endmodule

// File: tb/tb_ir_array_intf.sv
// tb_ir_array_intf: directed bench for ir_array_intf.
// Shortened timers: TMR_W=12 -> P=9 (period 512, window tmr 0..31, strobe at
// 31, smpl_vld at 34); BLANK_W=16 -> B=10 (blank 1023 clocks, so a masked
// rise ignores the next two evaluations).
module tb_ir_array_intf;

  localparam int NUM_CH = 3;

  logic              clk;
  logic              rst_n;
  logic [NUM_CH-1:0] IR_n;
  logic [2:0]        duty;
  logic [NUM_CH-1:0] blank_mask;
  logic              IR_en;
  logic [NUM_CH-1:0] IR;
  logic [NUM_CH-1:0] IR_rise;
  logic              smpl_vld;

  int errors = 0;
  int checks = 0;

  ir_array_intf #(
    .NUM_CH  (NUM_CH),
    .TMR_W   (12),
    .BLANK_W (16),
    .FILT    (2),
    .FAST_SIM(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .IR_n      (IR_n),
    .duty      (duty),
    .blank_mask(blank_mask),
    .IR_en     (IR_en),
    .IR        (IR),
    .IR_rise   (IR_rise),
    .smpl_vld  (smpl_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per sample period: active-high stimulus, mask, expected
  // outputs in the smpl_vld cycle.
  typedef struct {
    logic [2:0] act;
    logic [2:0] mask;
    logic [2:0] exp_ir;
    logic [2:0] exp_rise;
  } vec_t;

  vec_t tbl[24];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Advance negedge by negedge until smpl_vld is seen; cyc counts cycles.
  task automatic wait_vld(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!smpl_vld && cyc < 600);
    if (!smpl_vld) begin
      checks++;
      errors++;
      $display("FAIL vld_timeout: no smpl_vld within %0d cycles", cyc);
    end
  endtask

  // Starting at the negedge of tmr=0, count IR_en-high cycles inside and
  // outside the window over one period; optionally change duty at tmr=chg_at.
  task automatic meas_win(input int chg_at, input logic [2:0] chg_duty,
                          output int on_in, output int on_out);
    on_in  = 0;
    on_out = 0;
    for (int j = 0; j < 512; j++) begin
      if (j == chg_at) duty = chg_duty;
      if (IR_en) begin
        if (j < 32) on_in++;
        else        on_out++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int cyc;
    int on_in;
    int on_out;

    //            act     mask    ir      rise
    tbl[0]  = '{3'b000, 3'b010, 3'b000, 3'b000};
    tbl[1]  = '{3'b001, 3'b010, 3'b000, 3'b000};  // ch0 first agreeing sample
    tbl[2]  = '{3'b001, 3'b010, 3'b001, 3'b001};  // ch0 rises after FILT=2
    tbl[3]  = '{3'b101, 3'b010, 3'b001, 3'b000};  // ch2 one-period glitch
    tbl[4]  = '{3'b001, 3'b010, 3'b001, 3'b000};
    tbl[5]  = '{3'b001, 3'b010, 3'b001, 3'b000};
    tbl[6]  = '{3'b000, 3'b010, 3'b001, 3'b000};
    tbl[7]  = '{3'b000, 3'b010, 3'b000, 3'b000};
    tbl[8]  = '{3'b011, 3'b010, 3'b000, 3'b000};
    tbl[9]  = '{3'b011, 3'b010, 3'b011, 3'b011};  // ch1 rise starts blank
    tbl[10] = '{3'b000, 3'b010, 3'b011, 3'b000};  // ch1 blanked
    tbl[11] = '{3'b000, 3'b010, 3'b010, 3'b000};  // ch0 drops, ch1 blanked
    tbl[12] = '{3'b000, 3'b010, 3'b010, 3'b000};  // ch1 first evaluation
    tbl[13] = '{3'b000, 3'b010, 3'b000, 3'b000};  // ch1 drops
    tbl[14] = '{3'b101, 3'b010, 3'b000, 3'b000};
    tbl[15] = '{3'b101, 3'b010, 3'b101, 3'b101};  // simultaneous rises
    tbl[16] = '{3'b000, 3'b010, 3'b101, 3'b000};
    tbl[17] = '{3'b000, 3'b010, 3'b000, 3'b000};
    tbl[18] = '{3'b010, 3'b010, 3'b000, 3'b000};
    tbl[19] = '{3'b010, 3'b010, 3'b010, 3'b010};
    tbl[20] = '{3'b000, 3'b000, 3'b010, 3'b000};  // mask cleared mid-blank
    tbl[21] = '{3'b000, 3'b000, 3'b010, 3'b000};
    tbl[22] = '{3'b000, 3'b000, 3'b010, 3'b000};
    tbl[23] = '{3'b000, 3'b000, 3'b000, 3'b000};

    rst_n      = 1'b0;
    IR_n       = 3'b111;
    duty       = 3'd0;
    blank_mask = 3'b000;
    repeat (3) @(negedge clk);
    check("reset_outputs", {IR_en, IR, IR_rise, smpl_vld}, 32'h0);

    rst_n = 1'b1;
    wait_vld(cyc);
    check("first_vld_tmr", cyc, 34);

    for (int r = 0; r < 24; r++) begin
      IR_n       = ~tbl[r].act;
      blank_mask = tbl[r].mask;
      wait_vld(cyc);
      check($sformatf("row%0d_ir", r), IR, tbl[r].exp_ir);
      check($sformatf("row%0d_rise", r), IR_rise, tbl[r].exp_rise);
      @(negedge clk);
      check($sformatf("row%0d_pulse_end", r), {smpl_vld, IR_rise}, 32'h0);
    end

    // PWM: align to the start of the next window with duty just raised to 5.
    wait_vld(cyc);
    duty = 3'd5;
    repeat (478) @(negedge clk);
    meas_win(-1, 3'd0, on_in, on_out);   // first 8-clock frame still uses 0
    check("pwm_first_in", on_in, 15);
    check("pwm_first_out", on_out, 0);
    meas_win(10, 3'd2, on_in, on_out);   // duty changed mid-window
    check("pwm_d5_in", on_in, 20);
    check("pwm_d5_out", on_out, 0);
    meas_win(10, 3'd0, on_in, on_out);
    check("pwm_d2_in", on_in, 8);
    check("pwm_d2_out", on_out, 0);
    meas_win(-1, 3'd0, on_in, on_out);   // transitional window, not checked
    meas_win(-1, 3'd0, on_in, on_out);
    check("pwm_d0_in", on_in, 0);
    check("pwm_d0_out", on_out, 0);

    // Reset mid-window with all channels high and the emitter running.
    duty       = 3'd5;
    IR_n       = 3'b000;
    blank_mask = 3'b000;
    repeat (3) wait_vld(cyc);
    check("pre_reset_ir", IR, 3'b111);
    repeat (488) @(negedge clk);
    check("pre_reset_en", IR_en, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {IR_en, IR, IR_rise, smpl_vld}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_vld(cyc);
    check("post_reset_vld_tmr", cyc, 34);
    check("post_reset_ir", {IR, IR_rise}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
